regbank_arbiter: RTL

- Two-requester arbiter that shares the 8 x 16-bit, 2-read/1-write register bank between port A (core datapath) and port B (debug/DMA).
- Each accepted request is one bank transaction: two reads plus an optional write. Read data returns exactly one cycle after acceptance.
- Fairness is round-robin. A bounded lock lets a requester run atomic read-modify-write sequences.
- Sits directly in front of the bank. It is the only driver of the bank's address, write-enable and write-data inputs.

---
 rtl/regbank_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin arbiter with bounded lock in front of the
// 8 x 16-bit 2R/1W register bank. Ports A (core) and B (debug/DMA).
// Optional feature macro: RB_ARB_FWD_EN (same-transaction read-during-write
// forwarding of the new write data into the response).
module regbank_arbiter #(
    parameter int unsigned LOCK_MAX  = 4,
    parameter bit          START_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic        a_req_we,
    input  logic        a_req_lock,
    input  logic [2:0]  a_req_raddr1,
    input  logic [2:0]  a_req_raddr2,
    input  logic [2:0]  a_req_waddr,
    input  logic [15:0] a_req_wdata,
    output logic        a_rsp_valid,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic        b_req_we,
    input  logic        b_req_lock,
    input  logic [2:0]  b_req_raddr1,
    input  logic [2:0]  b_req_raddr2,
    input  logic [2:0]  b_req_waddr,
    input  logic [15:0] b_req_wdata,
    output logic        b_rsp_valid,
    output logic [15:0] rsp_rdata1,
    output logic [15:0] rsp_rdata2,
    output logic [2:0]  bank_raddr1,
    output logic [2:0]  bank_raddr2,
    output logic [2:0]  bank_waddr,
    output logic        bank_wen,
    output logic [15:0] bank_wdata,
    input  logic [15:0] bank_rdata1,
    input  logic [15:0] bank_rdata2,
    output logic        lock_active
);

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    localparam logic [0:0] PORT_A = 1'b0;
    localparam logic [0:0] PORT_B = 1'b1;

    logic          r_lock;
    logic [0:0]    r_owner;
    logic [CW-1:0] r_lock_cnt;
    logic [0:0]    r_pri;
    logic          r_rsp_a;
    logic          r_rsp_b;

    logic          w_lock_hold;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_gnt;
    logic          w_we;
    logic          w_lock_req;
    logic [AW-1:0] w_raddr1;
    logic [AW-1:0] w_raddr2;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [CW-1:0] w_cnt_inc;
    logic          w_cnt_max;
    logic          w_lock_nxt;
    logic [0:0]    w_owner_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [0:0]    w_pri_nxt;

    // Grant selection: live lock first, then round-robin among valid ports
    always_comb begin
        w_lock_hold = r_lock && ((r_owner == PORT_B) ? b_req_valid : a_req_valid);
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        if (!rst) begin
            if (w_lock_hold) begin
                w_gnt_a = (r_owner == PORT_A);
                w_gnt_b = (r_owner == PORT_B);
            end else if (a_req_valid && b_req_valid) begin
                w_gnt_a = (r_pri == PORT_A);
                w_gnt_b = (r_pri == PORT_B);
            end else begin
                w_gnt_a = a_req_valid;
                w_gnt_b = b_req_valid;
            end
        end
    end

    assign w_gnt       = w_gnt_a | w_gnt_b;
    assign a_req_ready = w_gnt_a;
    assign b_req_ready = w_gnt_b;
    assign lock_active = w_lock_hold;

    // Bank-side mux of the granted request; all zero when nothing is granted
    always_comb begin
        w_we       = 1'b0;
        w_lock_req = 1'b0;
        w_raddr1   = '0;
        w_raddr2   = '0;
        w_waddr    = '0;
        w_wdata    = '0;
        if (w_gnt_a) begin
            w_we       = a_req_we;
            w_lock_req = a_req_lock;
            w_raddr1   = a_req_raddr1;
            w_raddr2   = a_req_raddr2;
            w_waddr    = a_req_waddr;
            w_wdata    = a_req_wdata;
        end else if (w_gnt_b) begin
            w_we       = b_req_we;
            w_lock_req = b_req_lock;
            w_raddr1   = b_req_raddr1;
            w_raddr2   = b_req_raddr2;
            w_waddr    = b_req_waddr;
            w_wdata    = b_req_wdata;
        end
    end

    assign bank_wen    = w_we;
    assign bank_raddr1 = w_raddr1;
    assign bank_raddr2 = w_raddr2;
    assign bank_waddr  = w_waddr;
    assign bank_wdata  = w_wdata;

    // A stale lock (owner not requesting) counts from zero for a new grant
    assign w_cnt_inc = (w_lock_hold ? r_lock_cnt : CW'(0)) + CW'(1);
    assign w_cnt_max = (w_cnt_inc >= CW'(LOCK_MAX));

    // Lock / priority next state
    always_comb begin
        w_lock_nxt  = r_lock;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_lock_cnt;
        w_pri_nxt   = r_pri;
        if (w_gnt) begin
            if (w_lock_req && !w_cnt_max) begin
                w_lock_nxt  = 1'b1;
                w_owner_nxt = w_gnt_b ? PORT_B : PORT_A;
                w_cnt_nxt   = w_cnt_inc;
            end else begin
                // unlocked grant or forced release: priority to the other port
                w_lock_nxt = 1'b0;
                w_cnt_nxt  = '0;
                w_pri_nxt  = w_gnt_b ? PORT_A : PORT_B;
            end
        end else if (r_lock && !w_lock_hold) begin
            w_lock_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_owner    <= PORT_A;
            r_lock_cnt <= '0;
            r_pri      <= START_PRI;
        end else begin
            r_lock     <= w_lock_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_pri      <= w_pri_nxt;
        end
    end

    // Response valid follows the grant by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_a <= 1'b0;
            r_rsp_b <= 1'b0;
        end else begin
            r_rsp_a <= w_gnt_a;
            r_rsp_b <= w_gnt_b;
        end
    end

    assign a_rsp_valid = r_rsp_a;
    assign b_rsp_valid = r_rsp_b;

`ifdef RB_ARB_FWD_EN
    logic          r_fwd_we;
    logic [DW-1:0] r_fwd_wdata;
    logic          r_fwd_m1;
    logic          r_fwd_m2;

    // Capture the write of the granted transaction for read-during-write bypass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_we    <= 1'b0;
            r_fwd_wdata <= '0;
            r_fwd_m1    <= 1'b0;
            r_fwd_m2    <= 1'b0;
        end else begin
            r_fwd_we    <= w_we;
            r_fwd_wdata <= w_wdata;
            r_fwd_m1    <= (w_raddr1 == w_waddr);
            r_fwd_m2    <= (w_raddr2 == w_waddr);
        end
    end

    assign rsp_rdata1 = (r_fwd_we && r_fwd_m1) ? r_fwd_wdata : bank_rdata1;
    assign rsp_rdata2 = (r_fwd_we && r_fwd_m2) ? r_fwd_wdata : bank_rdata2;
`else
    // Bank returns pre-write data on a same-transaction address match
    assign rsp_rdata1 = bank_rdata1;
    assign rsp_rdata2 = bank_rdata2;
`endif

endmodule
